// File: rtl/lfsr_cipher_engine.sv
// rtl/lfsr_cipher_engine.sv - streaming LFSR cipher with preamble-based key recovery
//
// Purpose: byte-stream coprocessor. Encrypt XORs each payload with the LFSR
// state and prepends even parity in the MSB. Decrypt trains on a known
// space-padded preamble, searches the tap table for the pattern that explains
// the recovered keystream, then strips the keystream from the rest of the run.
//
// Optional build macro: LFSR_CIPHER_PARITY_CHK_EN enables the decrypt-side
// parity checker and par_err_cnt; when undefined par_err_cnt is tied to 0.
//
// Ports:
//   clk, init_n             clock, asynchronous active-low reset
//   start, mode             launch a run (IDLE/DONE only); 0 encrypt, 1 decrypt
//   cfg_taps, cfg_seed      encrypt tap pattern and seed (seed 0 behaves as 1)
//   in_valid/in_data/in_ready     input byte stream
//   out_valid/out_data/out_ready  output byte stream (registered)
//   busy, done, err         run status; done is a level held until next start
//   det_taps, det_idx       taps in use / table index found by decrypt
//   par_err_cnt             saturating count of input parity errors (decrypt)
module lfsr_cipher_engine #(
  parameter int                          LFSR_W     = 7,
  parameter int                          MSG_LEN    = 64,
  parameter logic [7:0]                  PAD_CHAR   = 8'h20,
  parameter int                          TRAIN_LEN  = 10,
  parameter int                          NUM_PTRN   = 9,
  parameter logic [NUM_PTRN*LFSR_W-1:0]  PTRN_TABLE = {7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A,
                                                       7'h72, 7'h78, 7'h48, 7'h60}
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              start,
  input  logic              mode,
  input  logic [LFSR_W-1:0] cfg_taps,
  input  logic [LFSR_W-1:0] cfg_seed,
  input  logic              in_valid,
  input  logic [LFSR_W:0]   in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [LFSR_W:0]   out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LFSR_W-1:0] det_taps,
  output logic [3:0]        det_idx,
  output logic [7:0]        par_err_cnt
);

  localparam int                CW          = $clog2(MSG_LEN + 1);
  localparam int                KW          = $clog2(TRAIN_LEN);
  localparam logic [CW-1:0]     MSG_END     = CW'(MSG_LEN);
  localparam logic [CW-1:0]     MSG_LAST    = CW'(MSG_LEN - 1);
  localparam logic [CW-1:0]     TRAIN_END   = CW'(TRAIN_LEN);
  localparam logic [CW-1:0]     TRAIN_LASTC = CW'(TRAIN_LEN - 1);
  localparam logic [KW-1:0]     K_LAST      = KW'(TRAIN_LEN - 1);
  localparam logic [3:0]        P_LAST      = 4'(NUM_PTRN - 1);
  localparam logic [LFSR_W-1:0] PAD         = PAD_CHAR[LFSR_W-1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_ENC, S_TRAIN, S_SEARCH, S_DRAIN, S_STREAM, S_DONE
  } state_t;

  function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] s,
                                             input logic [LFSR_W-1:0] t);
    return {s[LFSR_W-2:0], ^(s & t)};
  endfunction

  state_t            state_q, state_n;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] train_buf [TRAIN_LEN];
  logic [CW-1:0]     in_cnt_q, out_cnt_q;
  logic [KW-1:0]     k_q, k_prev;
  logic [3:0]        p_q;
  logic [LFSR_W-1:0] cur_ptrn, r_first, r_prev, r_cur, cipher_in;
  logic              in_fire, out_fire, out_free, match;

  assign out_free  = !out_valid || out_ready;
  assign out_fire  = out_valid && out_ready;
  assign in_fire   = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign cipher_in = in_data[LFSR_W-1:0] ^ lfsr_q;

  // Recovered keystream r[k] is the buffered ciphertext with the pad removed.
  assign k_prev   = k_q - KW'(1);
  assign cur_ptrn = PTRN_TABLE[int'(p_q) * LFSR_W +: LFSR_W];
  assign r_first  = train_buf[0] ^ PAD;
  assign r_prev   = train_buf[k_prev] ^ PAD;
  assign r_cur    = train_buf[k_q] ^ PAD;
  assign match    = (step(r_prev, cur_ptrn) == r_cur);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state_q <= S_IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_n = mode ? S_TRAIN : S_ENC;
      S_ENC, S_STREAM: begin
        in_ready = out_free && (in_cnt_q != MSG_END);
        if (out_fire && out_cnt_q == MSG_LAST) state_n = S_DONE;
      end
      S_TRAIN: begin
        in_ready = (in_cnt_q != TRAIN_END);
        if (in_valid && in_cnt_q == TRAIN_LASTC) state_n = S_SEARCH;
      end
      S_SEARCH: begin
        if (r_first == '0)                      state_n = S_DONE;
        else if (!match && p_q == P_LAST)       state_n = S_DONE;
        else if (match && k_q == K_LAST)        state_n = S_DRAIN;
      end
      S_DRAIN: if (out_free && k_q == K_LAST) state_n = S_STREAM;
      default: state_n = S_IDLE;
    endcase
  end

  // Training buffer holds payload bits only; its contents are don't-care at reset.
  always_ff @(posedge clk) begin
    if (state_q == S_TRAIN && in_fire) train_buf[in_cnt_q[KW-1:0]] <= in_data[LFSR_W-1:0];
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      lfsr_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      k_q       <= '0;
      p_q       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      det_taps  <= '0;
      det_idx   <= '0;
    end else begin
      if (out_fire) begin
        out_valid <= 1'b0;
        out_cnt_q <= out_cnt_q + CW'(1);
      end
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          in_cnt_q  <= '0;
          out_cnt_q <= '0;
          k_q       <= KW'(1);
          p_q       <= '0;
          err       <= 1'b0;
          det_idx   <= '0;
          det_taps  <= mode ? '0 : cfg_taps;
          lfsr_q    <= mode ? '0 : ((cfg_seed == '0) ? LFSR_W'(1) : cfg_seed);
        end
        S_ENC: if (in_fire) begin
          out_valid <= 1'b1;
          out_data  <= {^cipher_in, cipher_in};
          lfsr_q    <= step(lfsr_q, det_taps);
          in_cnt_q  <= in_cnt_q + CW'(1);
        end
        S_TRAIN: if (in_fire) in_cnt_q <= in_cnt_q + CW'(1);
        S_SEARCH: begin
          if (r_first == '0) begin
            err <= 1'b1;
          end else if (match) begin
            if (k_q == K_LAST) begin
              // Whole preamble explained: the LFSR continues one step past r[TRAIN_LEN-1].
              det_idx  <= p_q;
              det_taps <= cur_ptrn;
              lfsr_q   <= step(r_cur, cur_ptrn);
              k_q      <= '0;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end else if (p_q == P_LAST) begin
            err <= 1'b1;
          end else begin
            p_q <= p_q + 4'd1;
            k_q <= KW'(1);
          end
        end
        S_DRAIN: if (out_free) begin
          out_valid <= 1'b1;
          out_data  <= {1'b0, train_buf[k_q] ^ r_cur};
          k_q       <= k_q + KW'(1);
        end
        S_STREAM: if (in_fire) begin
          out_valid <= 1'b1;
          out_data  <= {1'b0, cipher_in};
          lfsr_q    <= step(lfsr_q, det_taps);
          in_cnt_q  <= in_cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef LFSR_CIPHER_PARITY_CHK_EN
  logic par_bad;
  assign par_bad = (in_data[LFSR_W] != ^in_data[LFSR_W-1:0]);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      par_err_cnt <= '0;
    end else if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
      par_err_cnt <= '0;
    end else if ((state_q == S_TRAIN || state_q == S_STREAM) && in_fire && par_bad
                 && par_err_cnt != 8'hFF) begin
      par_err_cnt <= par_err_cnt + 8'd1;
    end
  end
`else
  logic unused_in_msb;
  assign unused_in_msb = in_data[LFSR_W];
  assign par_err_cnt   = '0;
`endif

endmodule

// File: doc/lfsr_cipher_engine.md
Name: lfsr_cipher_engine

Overview:
- Hardware streaming LFSR cipher. Encrypts: byte XOR LFSR state, parity prepended in MSB. Decrypts: recovers LFSR seed and tap pattern from the known space-padded preamble, then strips the keystream.
- Parametrised successor to the software programs 1 and 2. Sits beside top_level's data memory as a byte-stream coprocessor and uses the same req/ack-style start/done handshake.

Parameters:
- LFSR_W, 7: LFSR width. Data payload width is LFSR_W; the byte is LFSR_W+1 bits, with parity in the MSB.
- MSG_LEN, 64: bytes per run.
- PAD_CHAR, 8'h20: known preamble character.
- TRAIN_LEN, 10: preamble bytes used for pattern search. Range 2..MSG_LEN.
- NUM_PTRN, 9: candidate tap patterns.
- PTRN_TABLE, {7'h7B,7'h7E,7'h5C,7'h69,7'h6A,7'h72,7'h78,7'h48,7'h60}: packed table; index 0 is the LSBs (0x60).

Ports:
- clk  in  1  clock
- init_n  in  1  asynchronous active-low reset
- start  in  1  launch run; sampled only in IDLE or DONE
- mode  in  1  0 = encrypt, 1 = decrypt
- cfg_taps  in  LFSR_W  encrypt tap pattern
- cfg_seed  in  LFSR_W  encrypt seed; 0 is replaced by 1
- in_valid  in  1  input byte valid
- in_data  in  LFSR_W+1  input byte
- in_ready  out  1  engine accepts in_data this cycle
- out_valid  out  1  output byte valid
- out_data  out  LFSR_W+1  output byte
- out_ready  in  1  downstream accepts
- busy  out  1  run in progress
- done  out  1  run complete; level, held until next start
- err  out  1  decrypt found no seed/pattern
- det_taps  out  LFSR_W  detected/used taps
- det_idx  out  4  detected table index
- par_err_cnt  out  8  saturating parity-error count

Behaviour:
- Async reset (init_n=0): all outputs 0; state IDLE; LFSR=0; counters 0; training buffer contents don't-care.
- LFSR step: next = {s[LFSR_W-2:0], ^(s & taps)}.
- Handshakes: a transfer occurs on a rising clk with valid&&ready. out_data/out_valid are registered and held stable until accepted. in_ready = 0 whenever the output register is full and not being drained.
- Run: exactly MSG_LEN input and MSG_LEN output transfers. start while busy is ignored. start in IDLE or DONE clears done/err/par_err_cnt/det_* and latches mode.
- States:
  - IDLE → (start) → ENC if mode=0, else TRAIN.
  - ENC: LFSR loaded with cfg_seed (0→1); det_taps=cfg_taps. Per accepted byte: out[LFSR_W-1:0] = in[LFSR_W-1:0] ^ s; out MSB = ^out[LFSR_W-1:0]; LFSR steps. Input MSB is ignored. After the MSG_LEN-th output is accepted → DONE.
  - TRAIN: accept TRAIN_LEN bytes into buffer; no output. Recovered r[k] = buf[k][LFSR_W-1:0] ^ PAD_CHAR[LFSR_W-1:0] → SEARCH.
  - SEARCH: one compare per cycle. For p = 0..NUM_PTRN-1 and k = 1..TRAIN_LEN-1, test step(r[k-1], PTRN_TABLE[p]) == r[k]. A mismatch moves to p+1, k=1. First full-match p wins (table order): det_idx=p, det_taps=PTRN_TABLE[p], LFSR = step^(TRAIN_LEN)(r[0]) → DRAIN. Worst case NUM_PTRN*(TRAIN_LEN-1) cycles. If r[0]==0 or no p matches → err=1, DONE; no output bytes; remaining input is not consumed (in_ready=0).
  - DRAIN: output buf[k][LFSR_W-1:0] ^ r[k], MSB=0, for k = 0..TRAIN_LEN-1 → STREAM.
  - STREAM: per accepted byte, out = {1'b0, in[LFSR_W-1:0] ^ s}; LFSR steps; MSG_LEN total outputs → DONE.
  - DONE: busy=0, done=1. start → new run.
- busy=1 in every state except IDLE/DONE.
- Parity (decrypt, see macro): per input byte, in[MSB] != ^in[LFSR_W-1:0] increments par_err_cnt, saturating at 255. Output is unaffected.
- Simultaneous in/out transfer in the same cycle is allowed; full-throughput 1 byte/cycle in ENC/STREAM.
- init_n asserted mid-run: immediate abort to IDLE, outputs zeroed.

Optional Feature:
- LFSR_CIPHER_PARITY_CHK_EN defined: parity checking and par_err_cnt active as above.
- Undefined: par_err_cnt tied to 0; no checker logic.

Test Plan:
- Encrypt, cfg_taps=0x60, cfg_seed=0x01, input 0x20,0x20,0x20 → out 0x21,0x22,0x24; done after 64th output.
- Encrypt, cfg_seed=0 → behaves as seed 0x01 (first out for 0x20 is 0x21).
- Decrypt the 64-byte ciphertext of "Knowledge comes, but wisdom lingers" at pre_length 10, taps 0x48, seed 0x5A → det_idx=1, det_taps=0x48, output equals padded plaintext (0x20×10, then 0x4B...), err=0.
- Decrypt with first byte 0x20 (recovered seed 0) → err=1, done=1, zero output transfers.
- Ciphertext with one MSB flipped, macro defined → par_err_cnt=1, data output unchanged. Macro undefined → 0.
- Random out_ready backpressure plus init_n pulse mid-STREAM → no lost or duplicated bytes before the pulse; all outputs 0 and IDLE after it; a new run is correct.
